multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/multicycle_control_unit.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, control FSM state encodings, ALUop codes.
// Also used by ALUcontrolUnit.
package cpu_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADDR  = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC     = 4'd6,
    ST_RWB      = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_IEXEC    = 4'd10,
    ST_IWB      = 4'd11,
    ST_HALT     = 4'd12,
    ST_TRAP     = 4'd13
  } state_t;

  localparam logic [3:0] OP_LW   = 4'h0;
  localparam logic [3:0] OP_SW   = 4'h1;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_ADDI = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_RTYPE = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_ADD   = 2'b10;
  localparam logic [1:0] ALU_PC    = 2'b11;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= 4'h2) && (op <= 4'h9);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait state and flags
// a timeout once the count reaches LIMIT (LIMIT=0 disables the timeout).
module mem_wait_timer
  import cpu_pkg::*;
#(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic ready,
  input  logic clear,
  output logic timeout
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] CAP = W'(LIMIT);

  logic [W-1:0] cnt;

  assign timeout = (LIMIT != 0) && waiting && !ready && (cnt == CAP);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (waiting && !ready && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM with memory wait timeout.
// Optional: CTRL_ILLEGAL_TRAP_EN traps illegal opcodes in TRAP.
module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [3:0] State,
  output logic       Halted,
  output logic       MemTimeout,
  output logic       IllegalOp
);

  state_t state;
  state_t next;
  logic   waiting;
  logic   timeout;

  // Branch resolution happens in the datapath via PCWriteCond & Zero.
  logic unused_zero;
  assign unused_zero = Zero;

  assign waiting = (state == ST_FETCH) || (state == ST_MEMREAD) ||
                   (state == ST_MEMWRITE);

  mem_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .waiting(waiting),
    .ready  (MemReady),
    .clear  ((next != state) || timeout),
    .timeout(timeout)
  );

  assign MemTimeout = timeout && !reset;
  assign State      = state;

  always_comb begin
    next = state;
    case (state)
      ST_FETCH:    if (MemReady) next = ST_DECODE;
      ST_DECODE: begin
        unique case (1'b1)
          (Opcode == OP_LW) || (Opcode == OP_SW): next = ST_MEMADDR;
          is_rtype(Opcode):       next = ST_EXEC;
          (Opcode == OP_BEQ):     next = ST_BRANCH;
          (Opcode == OP_JMP):     next = ST_JUMP;
          (Opcode == OP_ADDI):    next = ST_IEXEC;
          (Opcode == OP_HALT):    next = ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:                next = ST_TRAP;
`else
          default:                next = ST_FETCH;
`endif
        endcase
      end
      ST_MEMADDR:  next = (Opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  if (MemReady) next = ST_MEMWB;
                   else if (timeout) next = ST_FETCH;
      ST_MEMWRITE: if (MemReady || timeout) next = ST_FETCH;
      ST_MEMWB:    next = ST_FETCH;
      ST_EXEC:     next = ST_RWB;
      ST_RWB:      next = ST_FETCH;
      ST_BRANCH:   next = ST_FETCH;
      ST_JUMP:     next = ST_FETCH;
      ST_IEXEC:    next = ST_IWB;
      ST_IWB:      next = ST_FETCH;
      ST_HALT:     next = ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_TRAP:     next = ST_TRAP;
`endif
      default:     next = ST_FETCH;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign IllegalOp = illegal_q;
`else
  assign IllegalOp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_FETCH;
      Halted <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state  <= next;
      Halted <= (next == ST_HALT);
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= (next == ST_TRAP);
`endif
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    case (state)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUop   = ALU_PC;
        PCWrite = MemReady;
        IRWrite = MemReady;
      end
      ST_DECODE: begin
        ALUSrcB = 2'b11;
        ALUop   = ALU_PC;
      end
      ST_MEMADDR, ST_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = ALU_ADD;
      end
      ST_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      ST_IWB:  RegWrite = 1'b1;
      ST_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = ALU_RTYPE;
      end
      ST_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
    // An abandoned memory access must not commit anything.
    if (timeout) begin
      MemWrite    = 1'b0;
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      PCWriteCond = 1'b0;
    end
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSource    = 2'b00;
      ALUSrcB     = 2'b00;
      ALUop       = 2'b00;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit (TIMEOUT_CYCLES=4).
// Optional: CTRL_ILLEGAL_TRAP_EN selects the trap expectations.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Opcode;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB, ALUop;
  logic [3:0] State;
  logic       Halted, MemTimeout, IllegalOp;

  always #5 clk = ~clk;

  multicycle_control_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .State(State), .Halted(Halted),
    .MemTimeout(MemTimeout), .IllegalOp(IllegalOp)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  //  ALUSrcA,RegWrite,RegDst,PCSource,ALUSrcB,ALUop}
  localparam logic [15:0] C_ZERO   = 16'h0000;
  localparam logic [15:0] C_FETCH  = 16'h9207;
  localparam logic [15:0] C_FWAIT  = 16'h1007;
  localparam logic [15:0] C_DEC    = 16'h000F;
  localparam logic [15:0] C_ADDR   = 16'h010A;
  localparam logic [15:0] C_MRD    = 16'h3000;
  localparam logic [15:0] C_MWB    = 16'h0480;
  localparam logic [15:0] C_MWR    = 16'h2800;
  localparam logic [15:0] C_MWR_TO = 16'h2000;
  localparam logic [15:0] C_EXEC   = 16'h0100;
  localparam logic [15:0] C_RWB    = 16'h00C0;
  localparam logic [15:0] C_BR     = 16'h4111;
  localparam logic [15:0] C_JMP    = 16'h8020;
  localparam logic [15:0] C_IWB    = 16'h0080;

  // flags: {Halted, MemTimeout, IllegalOp}
  typedef struct {
    int         id;
    logic [3:0] st;
    logic [15:0] ctrl;
    logic [2:0] flg;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   nstep = 0;

  logic [15:0] act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
                ALUop};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (State !== e.st || act !== e.ctrl ||
          {Halted, MemTimeout, IllegalOp} !== e.flg) begin
        fails++;
        $display("FAIL step%0d: got st=%0d ctrl=%h flg=%b, want st=%0d ctrl=%h flg=%b",
                 e.id, State, act, {Halted, MemTimeout, IllegalOp},
                 e.st, e.ctrl, e.flg);
      end
    end
  end

  task automatic step(input logic rdy, input logic [3:0] op,
                      input logic z, input logic rst,
                      input logic [3:0] st, input logic [15:0] c,
                      input logic [2:0] f);
    exp_t e;
    #1;
    MemReady = rdy;
    Opcode   = op;
    Zero     = z;
    reset    = rst;
    e.id = nstep; e.st = st; e.ctrl = c; e.flg = f;
    q.push_back(e);
    nstep++;
    @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; MemReady = 1'b0; Opcode = 4'h0; Zero = 1'b0;
    @(posedge clk);
    step(1, 4'h0, 0, 1, 4'd0, C_ZERO, 3'b000);
    // R-type 0100
    step(1, 4'h4, 0, 0, 4'd0, C_FETCH, 3'b000);
    step(1, 4'h4, 0, 0, 4'd1, C_DEC,   3'b000);
    step(1, 4'h4, 0, 0, 4'd6, C_EXEC,  3'b000);
    step(1, 4'h4, 0, 0, 4'd7, C_RWB,   3'b000);
    // LW with three wait cycles in MEMREAD
    step(1, 4'h0, 0, 0, 4'd0, C_FETCH, 3'b000);
    step(1, 4'h0, 0, 0, 4'd1, C_DEC,   3'b000);
    step(1, 4'h0, 0, 0, 4'd2, C_ADDR,  3'b000);
    for (int i = 0; i < 3; i++)
      step(0, 4'h0, 0, 0, 4'd3, C_MRD, 3'b000);
    step(1, 4'h0, 0, 0, 4'd3, C_MRD,   3'b000);
    step(1, 4'h0, 0, 0, 4'd4, C_MWB,   3'b000);
    // BEQ with Zero=1
    step(1, 4'hA, 1, 0, 4'd0, C_FETCH, 3'b000);
    step(1, 4'hA, 1, 0, 4'd1, C_DEC,   3'b000);
    step(1, 4'hA, 1, 0, 4'd8, C_BR,    3'b000);
    // JMP
    step(1, 4'hB, 0, 0, 4'd0, C_FETCH, 3'b000);
    step(1, 4'hB, 0, 0, 4'd1, C_DEC,   3'b000);
    step(1, 4'hB, 0, 0, 4'd9, C_JMP,   3'b000);
    // ADDI
    step(1, 4'hC, 0, 0, 4'd0,  C_FETCH, 3'b000);
    step(1, 4'hC, 0, 0, 4'd1,  C_DEC,   3'b000);
    step(1, 4'hC, 0, 0, 4'd10, C_ADDR,  3'b000);
    step(1, 4'hC, 0, 0, 4'd11, C_IWB,   3'b000);
    // SW stuck: 4 wait cycles, then timeout with MemWrite dropped
    step(1, 4'h1, 0, 0, 4'd0, C_FETCH, 3'b000);
    step(1, 4'h1, 0, 0, 4'd1, C_DEC,   3'b000);
    step(1, 4'h1, 0, 0, 4'd2, C_ADDR,  3'b000);
    for (int i = 0; i < 4; i++)
      step(0, 4'h1, 0, 0, 4'd5, C_MWR, 3'b000);
    step(0, 4'h1, 0, 0, 4'd5, C_MWR_TO, 3'b010);
    // SW: MemReady wins on the would-be timeout cycle
    step(1, 4'h1, 0, 0, 4'd0, C_FETCH, 3'b000);
    step(1, 4'h1, 0, 0, 4'd1, C_DEC,   3'b000);
    step(1, 4'h1, 0, 0, 4'd2, C_ADDR,  3'b000);
    for (int i = 0; i < 4; i++)
      step(0, 4'h1, 0, 0, 4'd5, C_MWR, 3'b000);
    step(1, 4'h1, 0, 0, 4'd5, C_MWR,   3'b000);
    // FETCH timeout, then a normal fetch
    for (int i = 0; i < 4; i++)
      step(0, 4'h4, 0, 0, 4'd0, C_FWAIT, 3'b000);
    step(0, 4'h4, 0, 0, 4'd0, C_FWAIT, 3'b010);
    step(1, 4'h4, 0, 0, 4'd0, C_FETCH, 3'b000);
    // Reset in RWB: strobes forced off, fetch restarts
    step(1, 4'h4, 0, 0, 4'd1, C_DEC,   3'b000);
    step(1, 4'h4, 0, 0, 4'd6, C_EXEC,  3'b000);
    step(1, 4'h4, 0, 1, 4'd7, C_ZERO,  3'b000);
    step(1, 4'hF, 0, 0, 4'd0, C_FETCH, 3'b000);
    // HALT
    step(1, 4'hF, 0, 0, 4'd1,  C_DEC,  3'b000);
    step(1, 4'hF, 0, 0, 4'd12, C_ZERO, 3'b100);
    step(1, 4'hF, 0, 0, 4'd12, C_ZERO, 3'b100);
    step(1, 4'hF, 0, 1, 4'd12, C_ZERO, 3'b100);
    // Illegal opcode 1101
    step(1, 4'hD, 0, 0, 4'd0, C_FETCH, 3'b000);
    step(1, 4'hD, 0, 0, 4'd1, C_DEC,   3'b000);
`ifdef CTRL_ILLEGAL_TRAP_EN
    step(1, 4'hD, 0, 0, 4'd13, C_ZERO, 3'b001);
    step(1, 4'hD, 0, 0, 4'd13, C_ZERO, 3'b001);
    step(1, 4'hD, 0, 1, 4'd13, C_ZERO, 3'b001);
`endif
    step(1, 4'h4, 0, 0, 4'd0, C_FETCH, 3'b000);
    step(1, 4'h4, 0, 0, 4'd1, C_DEC,   3'b000);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
